// File: rtl/coprocessor_pkg.sv
// Shared definitions for the matrix-multiplier coprocessor: arbiter state
// encoding, arbitration mode constants and a width helper.
package coprocessor_pkg;

  // Arbiter states (kept as plain constants so existing code can compare them)
  localparam logic [0:0] ARB_IDLE    = 1'b0;
  localparam logic [0:0] ARB_GRANTED = 1'b1;

  // Arbitration modes
  localparam int PRIORITY_RR    = 0;
  localparam int PRIORITY_FIXED = 1;

  // Ceiling log2, never less than 1 so it can size a vector directly
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_picker.sv
// Combinational winner picker: scans the request vector upward from a start
// index, wrapping, skipping any port set in the exclude mask.
module rr_priority_picker
  import coprocessor_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = clog2_min1(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] requests,
  input  logic [IDX_W-1:0]     start,
  input  logic [NUM_PORTS-1:0] exclude,
  output logic [IDX_W-1:0]     winner,
  output logic                 found
);

  int cand;

  // First eligible requester at or after start, in wrapped order
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(start) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && requests[cand[IDX_W-1:0]] && !exclude[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares the coprocessor's single memory port among NUM_PORTS requesters
// (processing units plus main controller), with round-robin or fixed priority,
// bounded hold time with preemption, and a mux of the owner's access signals.
//
// Handshake: a requester raises its i_Requests bit and holds it for its whole
// access sequence; it owns the memory port exactly while its o_Grants bit is
// high. Ownership can be lost by preemption, in which case the requester keeps
// requesting and re-competes. Owners drop enables no later than the request.
module memory_port_arbiter
  import coprocessor_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int WORD_SIZE     = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int MAX_HOLD      = 16,
  parameter int PRIORITY_MODE = 0,
  parameter int IDX_W         = clog2_min1(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            i_Requests,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_Port_Address,
  input  logic [NUM_PORTS*WORD_SIZE-1:0]  i_Port_Write_Data,
  input  logic [NUM_PORTS-1:0]            i_Port_Read_Enable,
  input  logic [NUM_PORTS-1:0]            i_Port_Write_Enable,
  output logic [NUM_PORTS-1:0]            o_Grants,
  output logic                            o_Grant_Valid,
  output logic [IDX_W-1:0]                o_Grant_Index,
  output logic [ADDR_WIDTH-1:0]           o_Memory_Address,
  output logic [WORD_SIZE-1:0]            o_Memory_Write_Data,
  output logic                            o_Memory_Read_Enable,
  output logic                            o_Memory_Write_Enable,
  output logic [15:0]                     o_Preempt_Count,
  output logic [0:0]                      o_Arb_State
);

  localparam int HOLD_W     = clog2_min1(MAX_HOLD + 1);
  localparam int HOLD_LIMIT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

  logic [0:0]           r_State;
  logic [IDX_W-1:0]     r_Owner;
  logic [IDX_W-1:0]     r_Last_Owner;
  logic [HOLD_W-1:0]    r_Hold_Count;
  logic [NUM_PORTS-1:0] r_Grants;
  logic [15:0]          r_Preempt_Count;

  logic [IDX_W-1:0]     start_idx;
  logic [NUM_PORTS-1:0] exclude_mask;
  logic [IDX_W-1:0]     winner;
  logic                 found;
  logic                 owner_req;
  logic                 hold_expired;
  int                   owner_int;

  // Scan start and exclusion: the current owner never competes against itself
  always_comb begin
    if (PRIORITY_MODE == PRIORITY_FIXED)
      start_idx = '0;
    else if (r_Last_Owner == IDX_W'(NUM_PORTS - 1))
      start_idx = '0;
    else
      start_idx = r_Last_Owner + IDX_W'(1);
    exclude_mask = (r_State == ARB_GRANTED) ? (ONE_HOT0 << r_Owner) : '0;
    owner_req    = i_Requests[r_Owner];
    // >= rather than == so an owner whose count saturated while alone is
    // still preempted as soon as someone else shows up
    hold_expired = (MAX_HOLD != 0) && (r_Hold_Count >= HOLD_W'(HOLD_LIMIT));
  end

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .requests (i_Requests),
    .start    (start_idx),
    .exclude  (exclude_mask),
    .winner   (winner),
    .found    (found)
  );

  // Ownership FSM: grant, zero-bubble handoff on release, preemption on hold expiry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_State         <= ARB_IDLE;
      r_Owner         <= '0;
      r_Last_Owner    <= IDX_W'(NUM_PORTS - 1);
      r_Hold_Count    <= '0;
      r_Grants        <= '0;
      r_Preempt_Count <= '0;
    end else if (r_State == ARB_IDLE) begin
      if (found) begin
        r_State      <= ARB_GRANTED;
        r_Owner      <= winner;
        r_Hold_Count <= '0;
        r_Grants     <= ONE_HOT0 << winner;
      end
    end else if (!owner_req) begin
      r_Last_Owner <= r_Owner;
      r_Hold_Count <= '0;
      if (found) begin
        r_Owner  <= winner;
        r_Grants <= ONE_HOT0 << winner;
      end else begin
        r_State  <= ARB_IDLE;
        r_Owner  <= '0;
        r_Grants <= '0;
      end
    end else if (hold_expired && found) begin
      r_Last_Owner <= r_Owner;
      r_Owner      <= winner;
      r_Hold_Count <= '0;
      r_Grants     <= ONE_HOT0 << winner;
      if (r_Preempt_Count != 16'hFFFF) r_Preempt_Count <= r_Preempt_Count + 16'd1;
    end else if (r_Hold_Count < HOLD_W'(MAX_HOLD)) begin
      r_Hold_Count <= r_Hold_Count + HOLD_W'(1);
    end
  end

  // Owner's access signals reach memory only while a grant is valid
  always_comb begin
    owner_int             = int'(r_Owner);
    o_Memory_Address      = '0;
    o_Memory_Write_Data   = '0;
    o_Memory_Read_Enable  = 1'b0;
    o_Memory_Write_Enable = 1'b0;
    if (|r_Grants) begin
      o_Memory_Address      = i_Port_Address[owner_int*ADDR_WIDTH +: ADDR_WIDTH];
      o_Memory_Write_Data   = i_Port_Write_Data[owner_int*WORD_SIZE +: WORD_SIZE];
      o_Memory_Read_Enable  = i_Port_Read_Enable[r_Owner];
      o_Memory_Write_Enable = i_Port_Write_Enable[r_Owner];
    end
  end

  assign o_Grants        = r_Grants;
  assign o_Grant_Valid   = |r_Grants;
  assign o_Grant_Index   = (|r_Grants) ? r_Owner : '0;
  assign o_Preempt_Count = r_Preempt_Count;
  assign o_Arb_State     = r_State;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter. Three instances share the stimulus:
// 0 = round-robin MAX_HOLD 16, 1 = round-robin MAX_HOLD 3, 2 = fixed MAX_HOLD 3.
module tb_memory_port_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [39:0]  addr;
  logic [127:0] wdata;
  logic [3:0]   re;
  logic [3:0]   we;

  logic [3:0]  grants [3];
  logic        valid  [3];
  logic [1:0]  gidx   [3];
  logic [9:0]  maddr  [3];
  logic [31:0] mwdata [3];
  logic        mre    [3];
  logic        mwe    [3];
  logic [15:0] pcnt   [3];
  logic [0:0]  st     [3];

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [19:0] exp_q[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_port_arbiter #(
      .NUM_PORTS     (4),
      .WORD_SIZE     (32),
      .ADDR_WIDTH    (10),
      .MAX_HOLD      ((g == 0) ? 16 : 3),
      .PRIORITY_MODE ((g == 2) ? 1 : 0)
    ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .i_Requests            (req),
      .i_Port_Address        (addr),
      .i_Port_Write_Data     (wdata),
      .i_Port_Read_Enable    (re),
      .i_Port_Write_Enable   (we),
      .o_Grants              (grants[g]),
      .o_Grant_Valid         (valid[g]),
      .o_Grant_Index         (gidx[g]),
      .o_Memory_Address      (maddr[g]),
      .o_Memory_Write_Data   (mwdata[g]),
      .o_Memory_Read_Enable  (mre[g]),
      .o_Memory_Write_Enable (mwe[g]),
      .o_Preempt_Count       (pcnt[g]),
      .o_Arb_State           (st[g])
    );
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0; re = '0; we = '0; addr = '0; wdata = '0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: advance one cycle, pop the expected {preempt count, grants}
  task automatic step_and_check(input int d, input string tag);
    logic [19:0] e;
    tick();
    if (exp_q.size() == 0) begin
      total_cnt++;
      fail_cnt++;
      $display("FAIL %s observed=no-expectation expected=queued-entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {44'd0, pcnt[d], grants[d]}, {44'd0, e});
    end
  endtask

  function automatic logic [3:0] onehot(input int p);
    logic [3:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    req = '0; re = '0; we = '0; addr = '0; wdata = '0;
    #2;

    // ---- Reset values on every instance
    do_reset();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_grants_%0d", d), {60'd0, grants[d]}, 64'd0);
      check($sformatf("rst_valid_%0d", d), {63'd0, valid[d]}, 64'd0);
      check($sformatf("rst_idx_%0d", d), {62'd0, gidx[d]}, 64'd0);
      check($sformatf("rst_addr_%0d", d), {54'd0, maddr[d]}, 64'd0);
      check($sformatf("rst_we_%0d", d), {63'd0, mwe[d]}, 64'd0);
      check($sformatf("rst_pcnt_%0d", d), {48'd0, pcnt[d]}, 64'd0);
    end

    // ---- Single requester, MAX_HOLD 16: held well past 16 cycles, idle after
    addr[2*10 +: 10] = 10'h123;
    re[2] = 1'b1;
    req = 4'b0100;
    for (int n = 0; n < 20; n++) begin
      exp_q.push_back({16'd0, 4'b0100});
      step_and_check(0, $sformatf("single_c%0d", n));
    end
    check("single_idx", {62'd0, gidx[0]}, 64'd2);
    check("single_addr", {54'd0, maddr[0]}, 64'h123);
    check("single_re", {63'd0, mre[0]}, 64'd1);
    req = 4'b0000;
    exp_q.push_back({16'd0, 4'b0000});
    step_and_check(0, "single_release");
    check("single_idle_valid", {63'd0, valid[0]}, 64'd0);
    check("single_idle_addr", {54'd0, maddr[0]}, 64'd0);
    check("single_idle_re", {63'd0, mre[0]}, 64'd0);

    // ---- Round-robin fairness, MAX_HOLD 3: 0,1,2,3,0 each for 3 cycles
    do_reset();
    we = 4'b1111;
    req = 4'b1111;
    for (int n = 0; n < 15; n++) begin
      exp_q.push_back({16'(n / 3), onehot((n / 3) % 4)});
      step_and_check(1, $sformatf("rr_c%0d", n));
      check($sformatf("rr_idx_c%0d", n), {62'd0, gidx[1]}, 64'((n / 3) % 4));
    end
    check("rr_we_pass", {63'd0, mwe[1]}, 64'd1);

    // ---- Asynchronous reset mid-grant, no clock edge in between
    #2;
    reset = 1'b0;
    #1;
    check("arst_grants", {60'd0, grants[1]}, 64'd0);
    check("arst_we", {63'd0, mwe[1]}, 64'd0);
    check("arst_pcnt", {48'd0, pcnt[1]}, 64'd0);

    // ---- Fixed priority, MAX_HOLD 3: 1 owns, 0 joins, 3 starves
    do_reset();
    req = 4'b1010;
    exp_q.push_back({16'd0, 4'b0010});
    step_and_check(2, "fix_first");
    req = 4'b1011;
    exp_q.push_back({16'd0, 4'b0010});
    exp_q.push_back({16'd0, 4'b0010});
    exp_q.push_back({16'd1, 4'b0001});
    exp_q.push_back({16'd1, 4'b0001});
    exp_q.push_back({16'd1, 4'b0001});
    exp_q.push_back({16'd2, 4'b0010});
    exp_q.push_back({16'd2, 4'b0010});
    exp_q.push_back({16'd2, 4'b0010});
    exp_q.push_back({16'd3, 4'b0001});
    for (int n = 0; n < 9; n++) step_and_check(2, $sformatf("fix_c%0d", n));
    req = 4'b1010;
    exp_q.push_back({16'd3, 4'b0010});
    step_and_check(2, "fix_drop0");
    req = 4'b1000;
    exp_q.push_back({16'd3, 4'b1000});
    step_and_check(2, "fix_port3");

    // ---- Zero-bubble release: 0001 -> 0010 on consecutive cycles
    do_reset();
    req = 4'b0001;
    exp_q.push_back({16'd0, 4'b0001});
    step_and_check(1, "zb_grant0");
    req = 4'b0011;
    exp_q.push_back({16'd0, 4'b0001});
    step_and_check(1, "zb_hold0");
    req = 4'b0010;
    exp_q.push_back({16'd0, 4'b0010});
    step_and_check(1, "zb_handoff");

    // ---- Muxing: only the owner's signals reach memory
    do_reset();
    addr[3*10 +: 10]  = 10'h3FF;
    wdata[3*32 +: 32] = 32'hDEADBEEF;
    addr[1*10 +: 10]  = 10'h155;
    wdata[1*32 +: 32] = 32'h12345678;
    we = 4'b1010;
    req = 4'b1000;
    exp_q.push_back({16'd0, 4'b1000});
    step_and_check(0, "mux_grant3");
    req = 4'b1010;
    exp_q.push_back({16'd0, 4'b1000});
    step_and_check(0, "mux_hold3");
    check("mux_addr", {54'd0, maddr[0]}, 64'h3FF);
    check("mux_data", {32'd0, mwdata[0]}, 64'hDEADBEEF);
    check("mux_we", {63'd0, mwe[0]}, 64'd1);
    check("mux_re", {63'd0, mre[0]}, 64'd0);
    check("mux_idx", {62'd0, gidx[0]}, 64'd3);
    req = 4'b0000;
    exp_q.push_back({16'd0, 4'b0000});
    step_and_check(0, "mux_release");
    check("mux_idle_addr", {54'd0, maddr[0]}, 64'd0);
    check("mux_idle_data", {32'd0, mwdata[0]}, 64'd0);
    check("mux_idle_we", {63'd0, mwe[0]}, 64'd0);
    check("mux_idle_idx", {62'd0, gidx[0]}, 64'd0);
    check("mux_idle_valid", {63'd0, valid[0]}, 64'd0);

    // ---- Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
